id_ex_stage: RTL and testbench

- ID/EX pipeline register for the RV32I core; sits directly upstream of the ALU and drives its two operands and 4-bit op code.
- Selects operand sources (rs1/PC, rs2/imm) and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Registers the result behind a valid/ready handshake with stall and flush support.

---
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core.
// Selects ALU operand sources, resolves RAW hazards by forwarding from EX/MEM and MEM/WB,
// and holds the result behind a valid/ready handshake with stall and flush support.
module id_ex_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    // Decode side
    input  logic               i_id_valid,
    output logic               o_id_ready,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [4:0]         i_rs1_addr,
    input  logic [4:0]         i_rs2_addr,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [XLEN-1:0]    i_rs2_data,
    input  logic [XLEN-1:0]    i_imm,
    input  logic [ALUOP_W-1:0] i_alu_op,
    input  logic               i_op_a_sel,
    input  logic               i_op_b_sel,
    input  logic [4:0]         i_rd_addr,
    input  logic               i_rd_we,
    // Forwarding sources
    input  logic               i_exmem_rd_we,
    input  logic [4:0]         i_exmem_rd_addr,
    input  logic [XLEN-1:0]    i_exmem_data,
    input  logic               i_memwb_rd_we,
    input  logic [4:0]         i_memwb_rd_addr,
    input  logic [XLEN-1:0]    i_memwb_data,
    // Control
    input  logic               i_flush,
    input  logic               i_ex_ready,
    // Execute side
    output logic               o_ex_valid,
    output logic [XLEN-1:0]    o_op_a,
    output logic [XLEN-1:0]    o_op_b,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic [XLEN-1:0]    o_store_data,
    output logic [4:0]         o_rd_addr,
    output logic               o_rd_we,
    output logic [XLEN-1:0]    o_pc
);

    logic               r_ex_valid;
    logic [XLEN-1:0]    r_op_a;
    logic [XLEN-1:0]    r_op_b;
    logic [ALUOP_W-1:0] r_alu_op;
    logic [XLEN-1:0]    r_store_data;
    logic [4:0]         r_rd_addr;
    logic               r_rd_we;
    logic [XLEN-1:0]    r_pc;

    logic               w_accept;
    logic [XLEN-1:0]    w_fwd_rs1;
    logic [XLEN-1:0]    w_fwd_rs2;

    // Ready depends only on the held slot, never on i_id_valid, to avoid a comb loop upstream.
    assign o_id_ready = !r_ex_valid || i_ex_ready;
    assign w_accept   = i_id_valid && o_id_ready && !i_flush;

    // rs1 forwarding: EX/MEM beats MEM/WB beats register file; x0 never forwards.
    always_comb begin
        w_fwd_rs1 = i_rs1_data;
        if (i_rs1_addr != 5'd0) begin
            if (i_exmem_rd_we && (i_exmem_rd_addr == i_rs1_addr)) begin
                w_fwd_rs1 = i_exmem_data;
            end else if (i_memwb_rd_we && (i_memwb_rd_addr == i_rs1_addr)) begin
                w_fwd_rs1 = i_memwb_data;
            end
        end
    end

    // rs2 forwarding: same priority as rs1.
    always_comb begin
        w_fwd_rs2 = i_rs2_data;
        if (i_rs2_addr != 5'd0) begin
            if (i_exmem_rd_we && (i_exmem_rd_addr == i_rs2_addr)) begin
                w_fwd_rs2 = i_exmem_data;
            end else if (i_memwb_rd_we && (i_memwb_rd_addr == i_rs2_addr)) begin
                w_fwd_rs2 = i_memwb_data;
            end
        end
    end

    // Pipeline register: flush beats capture beats drain; otherwise everything holds (stall).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ex_valid   <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_alu_op     <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_rd_we      <= 1'b0;
            r_pc         <= '0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
            r_rd_we    <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid   <= 1'b1;
            r_op_a       <= i_op_a_sel ? i_pc : w_fwd_rs1;
            r_op_b       <= i_op_b_sel ? i_imm : w_fwd_rs2;
            r_alu_op     <= i_alu_op;
            r_store_data <= w_fwd_rs2;
            r_rd_addr    <= i_rd_addr;
            r_rd_we      <= i_rd_we;
            r_pc         <= i_pc;
        end else if (r_ex_valid && i_ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign o_ex_valid   = r_ex_valid;
    assign o_op_a       = r_op_a;
    assign o_op_b       = r_op_b;
    assign o_alu_op     = r_alu_op;
    assign o_store_data = r_store_data;
    assign o_rd_addr    = r_rd_addr;
    // A drained slot keeps its payload, so the write enable must be qualified here.
    assign o_rd_we      = r_rd_we && r_ex_valid;
    assign o_pc         = r_pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic,
// compared against a transaction-level reference model of the stage.
module tb_id_ex_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_id_valid;
    logic        o_id_ready;
    logic [31:0] i_pc;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_imm;
    logic [3:0]  i_alu_op;
    logic        i_op_a_sel;
    logic        i_op_b_sel;
    logic [4:0]  i_rd_addr;
    logic        i_rd_we;
    logic        i_exmem_rd_we;
    logic [4:0]  i_exmem_rd_addr;
    logic [31:0] i_exmem_data;
    logic        i_memwb_rd_we;
    logic [4:0]  i_memwb_rd_addr;
    logic [31:0] i_memwb_data;
    logic        i_flush;
    logic        i_ex_ready;
    logic        o_ex_valid;
    logic [31:0] o_op_a;
    logic [31:0] o_op_b;
    logic [3:0]  o_alu_op;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd_addr;
    logic        o_rd_we;
    logic [31:0] o_pc;

    id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_id_valid      (i_id_valid),
        .o_id_ready      (o_id_ready),
        .i_pc            (i_pc),
        .i_rs1_addr      (i_rs1_addr),
        .i_rs2_addr      (i_rs2_addr),
        .i_rs1_data      (i_rs1_data),
        .i_rs2_data      (i_rs2_data),
        .i_imm           (i_imm),
        .i_alu_op        (i_alu_op),
        .i_op_a_sel      (i_op_a_sel),
        .i_op_b_sel      (i_op_b_sel),
        .i_rd_addr       (i_rd_addr),
        .i_rd_we         (i_rd_we),
        .i_exmem_rd_we   (i_exmem_rd_we),
        .i_exmem_rd_addr (i_exmem_rd_addr),
        .i_exmem_data    (i_exmem_data),
        .i_memwb_rd_we   (i_memwb_rd_we),
        .i_memwb_rd_addr (i_memwb_rd_addr),
        .i_memwb_data    (i_memwb_data),
        .i_flush         (i_flush),
        .i_ex_ready      (i_ex_ready),
        .o_ex_valid      (o_ex_valid),
        .o_op_a          (o_op_a),
        .o_op_b          (o_op_b),
        .o_alu_op        (o_alu_op),
        .o_store_data    (o_store_data),
        .o_rd_addr       (o_rd_addr),
        .o_rd_we         (o_rd_we),
        .o_pc            (o_pc)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the one instruction slot the stage holds.
    logic        m_valid;
    logic        m_known;   // payload defined (not after a flush)
    logic [31:0] m_op_a, m_op_b, m_store, m_pc;
    logic [3:0]  m_alu;
    logic [4:0]  m_rd;
    logic        m_rd_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] src, input logic [31:0] rf);
        if (src != 5'd0 && i_exmem_rd_we && i_exmem_rd_addr == src) return i_exmem_data;
        if (src != 5'd0 && i_memwb_rd_we && i_memwb_rd_addr == src) return i_memwb_data;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_known = 1'b1; m_op_a = '0; m_op_b = '0; m_store = '0;
        m_pc = '0; m_alu = '0; m_rd = '0; m_rd_we = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(o_ex_valid), 32'(m_valid));
        check({tag, ".rd_we"}, 32'(o_rd_we), 32'(m_valid && m_rd_we));
        if (m_known) begin
            check({tag, ".op_a"},  o_op_a, m_op_a);
            check({tag, ".op_b"},  o_op_b, m_op_b);
            check({tag, ".store"}, o_store_data, m_store);
            check({tag, ".alu"},   32'(o_alu_op), 32'(m_alu));
            check({tag, ".rd"},    32'(o_rd_addr), 32'(m_rd));
            check({tag, ".pc"},    o_pc, m_pc);
        end
    endtask

    // Check ready before the edge, advance the model one cycle, then check outputs after it.
    task automatic tick(input string tag);
        logic acc;
        #1;
        check({tag, ".ready"}, 32'(o_id_ready), 32'(!m_valid || i_ex_ready));
        acc = i_id_valid && (!m_valid || i_ex_ready) && !i_flush;
        if (i_rst) begin
            model_reset();
        end else if (i_flush) begin
            m_valid = 1'b0; m_rd_we = 1'b0; m_known = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1; m_known = 1'b1;
            m_op_a  = i_op_a_sel ? i_pc  : fwd_ref(i_rs1_addr, i_rs1_data);
            m_op_b  = i_op_b_sel ? i_imm : fwd_ref(i_rs2_addr, i_rs2_data);
            m_store = fwd_ref(i_rs2_addr, i_rs2_data);
            m_alu = i_alu_op; m_rd = i_rd_addr; m_rd_we = i_rd_we; m_pc = i_pc;
        end else if (m_valid && i_ex_ready) begin
            m_valid = 1'b0;
        end
        @(posedge i_clk);
        #1;
        check_outputs(tag);
    endtask

    // Random instruction; small register indices make forwarding hits common.
    task automatic rand_instr();
        i_pc       = $urandom;
        i_rs1_addr = 5'($urandom_range(0, 3));
        i_rs2_addr = 5'($urandom_range(0, 3));
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_imm      = $urandom;
        i_alu_op   = 4'($urandom_range(0, 15));
        i_op_a_sel = 1'($urandom_range(0, 1));
        i_op_b_sel = 1'($urandom_range(0, 1));
        i_rd_addr  = 5'($urandom_range(0, 31));
        i_rd_we    = 1'($urandom_range(0, 1));
        i_exmem_rd_we   = 1'($urandom_range(0, 1));
        i_exmem_rd_addr = 5'($urandom_range(0, 3));
        i_exmem_data    = $urandom;
        i_memwb_rd_we   = 1'($urandom_range(0, 1));
        i_memwb_rd_addr = 5'($urandom_range(0, 3));
        i_memwb_data    = $urandom;
    endtask

    task automatic no_fwd();
        i_exmem_rd_we = 1'b0;
        i_memwb_rd_we = 1'b0;
    endtask

    initial begin
        // Reset
        i_rst = 1'b1; rand_instr(); i_id_valid = 1'b0; i_flush = 1'b0; i_ex_ready = 1'b1;
        model_reset();
        @(posedge i_clk); @(posedge i_clk); #1;
        check_outputs("reset");
        i_rst = 1'b0;
        tick("idle");

        // Basic pass and back-to-back accept
        rand_instr(); no_fwd();
        i_id_valid = 1'b1; i_rs1_data = 32'd5; i_imm = 32'd7; i_op_a_sel = 1'b0;
        i_op_b_sel = 1'b1; i_alu_op = 4'b0000; i_ex_ready = 1'b1;
        tick("basic");
        check("basic.op_a_lit", o_op_a, 32'd5);
        check("basic.op_b_lit", o_op_b, 32'd7);
        rand_instr();
        tick("b2b");

        // Forward priority: EX/MEM over MEM/WB, then MEM/WB alone
        rand_instr();
        i_rs1_addr = 5'd3; i_op_a_sel = 1'b0;
        i_exmem_rd_we = 1'b1; i_exmem_rd_addr = 5'd3; i_exmem_data = 32'hAAAA_0000;
        i_memwb_rd_we = 1'b1; i_memwb_rd_addr = 5'd3; i_memwb_data = 32'h0000_5555;
        tick("fwd_ex");
        check("fwd_ex.lit", o_op_a, 32'hAAAA_0000);
        i_exmem_rd_we = 1'b0;
        tick("fwd_wb");
        check("fwd_wb.lit", o_op_a, 32'h0000_5555);

        // x0 guard
        rand_instr();
        i_rs2_addr = 5'd0; i_rs2_data = 32'd0; i_op_b_sel = 1'b0;
        i_exmem_rd_we = 1'b1; i_exmem_rd_addr = 5'd0; i_exmem_data = 32'h0000_DEAD;
        tick("x0");
        check("x0.op_b_lit", o_op_b, 32'd0);
        check("x0.store_lit", o_store_data, 32'd0);

        // Stall then drain: A held for 3 cycles, B captured as A drains
        rand_instr(); i_ex_ready = 1'b1;
        tick("stall_capA");
        rand_instr(); i_ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("stall_hold");
            check("stall.ready_lit", 32'(o_id_ready), 32'd0);
        end
        i_ex_ready = 1'b1;
        tick("stall_capB");

        // Flush beats capture; dropped instruction never appears
        rand_instr(); i_flush = 1'b1;
        tick("flush");
        check("flush.valid_lit", 32'(o_ex_valid), 32'd0);
        i_flush = 1'b0; i_id_valid = 1'b0;
        tick("flush_after");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_instr();
            i_id_valid = ($urandom_range(0, 9) < 7);
            i_ex_ready = ($urandom_range(0, 9) < 7);
            i_flush    = ($urandom_range(0, 9) == 0);
            tick("rand");
        end
        i_flush = 1'b0;

        // Reset asserted mid-stall clears outputs immediately
        rand_instr(); i_id_valid = 1'b1; i_ex_ready = 1'b1;
        tick("rst_capA");
        i_ex_ready = 1'b0;
        tick("rst_stall");
        i_rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        check("rst_async.alu_lit", 32'(o_alu_op), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        #1;
        check("rst_release.ready", 32'(o_id_ready), 32'd1);
        rand_instr();
        tick("rst_recap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
